bb_uart_txq: RTL and testbench
==============================

# bb_uart_txq

Transmit queue and handshake sequencer that sits directly upstream of the UART transmitter on the ispMACH 4256ZE breakout board. It buffers bytes from on-chip producer logic in a small synchronous FIFO, then hands them one at a time to the transmitter through its `txen`/`txreg`/`txbsy` handshake. The producer does not need to track transmitter state. Everything runs on the baud clock, in the same domain as the transmitter.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 entries (8 by default).
- `TO_CYCLES`, default 4: number of WAIT_BSY cycles without seeing `txbsy` before the byte is abandoned; minimum 2.
- `bdclk` input, 1 bit: baud clock. All logic is clocked on posedge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `wr_en` input, 1 bit: producer write strobe, one byte per cycle.
- `wr_data` input, 8 bits: byte to enqueue.
- `clr_flags` input, 1 bit: clears `ovf` and `err`.
- `txbsy` input, 1 bit: busy flag from the transmitter.
- `txen` output, 1 bit: transmit-start pulse to the transmitter; registered.
- `txreg` output, 8 bits: byte presented to the transmitter; registered.
- `full` output, 1 bit: `count` == 2^DEPTH_LOG2.
- `empty` output, 1 bit: `count` == 0.
- `count` output, DEPTH_LOG2+1 bits: current occupancy.
- `ovf` output, 1 bit: sticky flag; a write was dropped.
- `err` output, 1 bit: sticky flag; handshake timeout, byte lost.

## Operation
- FIFO storage:
  - Register array, read/write pointers of DEPTH_LOG2 bits each, wrapping modulo depth.
  - `count` is a separate register, DEPTH_LOG2+1 bits wide.
- Write rules:
  - A write is accepted on an edge with `wr_en`=1 and `full`=0.
  - If `full`=1, the write is dropped and `ovf` is set, even if a pop happens on the same edge.
- Simultaneous accepted write and pop: both pointers advance and `count` is unchanged.
- Sequencer FSM, states IDLE, WAIT_BSY, WAIT_IDLE:
  - IDLE, with `empty`=0 and `txbsy`=0: `txen`<=1, `txreg`<=FIFO head, head popped, timeout counter<=0, go to WAIT_BSY.
  - IDLE, otherwise: stay in IDLE.
  - WAIT_BSY: `txen`<=0, so the pulse is exactly one cycle.
    - If `txbsy`=1, go to WAIT_IDLE.
    - Else if the counter equals TO_CYCLES-1, set `err` and go to IDLE.
    - Else increment the counter.
  - WAIT_IDLE: when `txbsy`=0, go to IDLE.
- `txreg` holds its value from the issue edge until the next issue, so it stays stable throughout the handshake.
- `clr_flags` clears `ovf` and `err` on the edge. If a new overflow or timeout happens on the same edge, the set wins.
- Reset values:
  - state IDLE, pointers 0, `count` 0.
  - `txen` 0, `txreg` 8'h00.
  - `ovf` 0, `err` 0, `empty` 1, `full` 0.
  - FIFO contents are not reset.
- Reset mid-operation: the queue is flushed and `txen` is dropped on that same edge. The transmitter shares `rst`, so the two blocks return to idle together.

## Timing
- First-write latency:
  - Write accepted at edge N; `empty`=0 after N.
  - Issue at edge N+1: `txen` is high during the N+1..N+2 cycle.
  - The transmitter samples `txen` at N+2, and `txbsy` is seen from N+2.
- `txen` is never high on two consecutive cycles.
- `txen` is never asserted while `txbsy`=1 or while the state is not IDLE.
- Back-to-back gap:
  - `txbsy` falls at edge M; WAIT_IDLE→IDLE at M+1; next `txen` issued at M+2.
  - This gives 2 idle bdclk cycles between frames on top of the transmitter's stop time.
- `count`, `full` and `empty` are all registered and update on the edge of the write or pop.
- `ovf` and `err` assert on the edge of the offending event.

## Test plan
- Reset, then write 8'hA5 once:
  - `txen` pulses for one cycle, 1 cycle after the write edge, with `txreg`=8'hA5.
  - `count` goes 1→0.
  - Model `txbsy` high for 11 cycles; no second `txen`.
- Burst of 8 writes, 8'h01..8'h08, on consecutive cycles, DEPTH_LOG2=3:
  - `full`=1 after the 8th write, or earlier release occurs via pop; a 9th write while `full`=1 sets `ovf`.
  - Bytes reach `txreg` in order 01..08.
  - Each `txen` comes exactly 2 cycles after the previous `txbsy` fall.
- Write and pop on the same edge with `count`=3: `count` stays 3 and the pointers wrap correctly past index 7.
- `txbsy` held at 0 after `txen`: `err`=1 exactly TO_CYCLES cycles after the pulse; FSM returns to IDLE and issues the next byte. `clr_flags` then clears `err`.
- Assert `rst` while in WAIT_IDLE with `count`=4: next edge gives `count`=0, `empty`=1, `txen`=0, state IDLE, and flags cleared.

Source files
------------

// File: rtl/bb_uart_txq.sv
// Transmit queue for the board UART: buffers producer bytes in a small FIFO and
// feeds them one at a time to the transmitter over the txen/txreg/txbsy handshake.
module bb_uart_txq #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TO_CYCLES  = 4
) (
  input  logic                  bdclk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  clr_flags,
  input  logic                  txbsy,
  output logic                  txen,
  output logic [7:0]            txreg,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  output logic                  err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TO_W  = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TO_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  // IDLE: issue head when queued and tx idle | WAIT_BSY: await txbsy or time out | WAIT_IDLE: await txbsy fall
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BSY  = 2'd1,
    S_WAIT_IDLE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  txen_q, txen_d;
  logic [7:0]            txreg_q, txreg_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [7:0]            mem_q [DEPTH];

  logic push;
  logic pop;
  logic timeout;

  // Sequencer
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    txen_d   = 1'b0;
    txreg_d  = txreg_q;
    pop      = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && !txbsy) begin
          txen_d   = 1'b1;
          txreg_d  = mem_q[rd_ptr_q];
          pop      = 1'b1;
          to_cnt_d = '0;
          state_d  = S_WAIT_BSY;
        end
      end
      S_WAIT_BSY: begin
        if (txbsy) begin
          state_d = S_WAIT_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (!txbsy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a write while full is dropped even if a pop frees a slot
  always_comb begin
    push     = wr_en && !full_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // Sticky flags: a new event on the clear edge wins
  always_comb begin
    ovf_d = ovf_q;
    err_d = err_q;
    if (clr_flags) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end
    if (wr_en && full_q) ovf_d = 1'b1;
    if (timeout)         err_d = 1'b1;
  end

  always_ff @(posedge bdclk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      txen_q   <= 1'b0;
      txreg_q  <= 8'h00;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      txen_q   <= txen_d;
      txreg_q  <= txreg_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge bdclk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

  assign txen  = txen_q;
  assign txreg = txreg_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bb_uart_txq.sv
// Directed bench for bb_uart_txq with a simple transmitter model that answers txen
// with an 11-cycle txbsy window and logs every issued byte.
module tb_bb_uart_txq;

  logic       bdclk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_flags;
  logic       txbsy;
  logic       txen;
  logic [7:0] txreg;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       ovf;
  logic       err;

  bb_uart_txq #(.DEPTH_LOG2(3), .TO_CYCLES(4)) dut (
    .bdclk     (bdclk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_flags (clr_flags),
    .txbsy     (txbsy),
    .txen      (txen),
    .txreg     (txreg),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf),
    .err       (err)
  );

  initial bdclk = 1'b0;
  always #5 bdclk = ~bdclk;

  // Transmitter model
  logic       tx_resp;
  logic       hold_bsy;
  logic       busy_q;
  int         bcnt;
  int         cyc;
  int         last_fall;
  int         n_issued;
  int         viol;
  logic       txen_prev;
  logic [7:0] log_b [0:31];
  int         gap_l [0:31];

  assign txbsy = busy_q | hold_bsy;

  initial begin
    busy_q    = 1'b0;
    bcnt      = 0;
    cyc       = 0;
    last_fall = 0;
    n_issued  = 0;
    viol      = 0;
    txen_prev = 1'b0;
  end

  always @(posedge bdclk) begin
    cyc       <= cyc + 1;
    txen_prev <= txen;
    if (rst) begin
      busy_q <= 1'b0;
      bcnt   <= 0;
    end else begin
      if (txen === 1'b1) begin
        if (txbsy || txen_prev) viol <= viol + 1;
        if (n_issued < 32) begin
          log_b[n_issued] <= txreg;
          gap_l[n_issued] <= cyc - 1 - last_fall;
        end
        n_issued <= n_issued + 1;
      end
      if (txen === 1'b1 && tx_resp) begin
        busy_q <= 1'b1;
        bcnt   <= 11;
      end else if (bcnt == 1) begin
        busy_q    <= 1'b0;
        bcnt      <= 0;
        last_fall <= cyc;
      end else if (bcnt > 1) begin
        bcnt <= bcnt - 1;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge bdclk);
    @(negedge bdclk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_drain(input int target, input int budget);
    int i = 0;
    while ((n_issued < target || busy_q) && i < budget) begin
      tick();
      i++;
    end
    repeat (2) tick();
    check("drain_issued", n_issued, target);
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    clr_flags = 1'b0;
    tx_resp   = 1'b1;
    hold_bsy  = 1'b0;
    repeat (3) tick();

    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full",  full,  0);
    check("rst_txen",  txen,  0);
    check("rst_txreg", txreg, 8'h00);
    check("rst_ovf",   ovf,   0);
    check("rst_err",   err,   0);
    rst = 1'b0;
    tick();

    // Single byte
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("t1_count_after_wr", count, 1);
    check("t1_empty_after_wr", empty, 0);
    check("t1_txen_early",     txen,  0);
    tick();
    check("t1_txen_pulse", txen,  1);
    check("t1_txreg",      txreg, 8'hA5);
    check("t1_count_pop",  count, 0);
    check("t1_empty_pop",  empty, 1);
    tick();
    check("t1_txen_low",   txen,  0);
    check("t1_txbsy",      txbsy, 1);
    check("t1_txreg_hold", txreg, 8'hA5);
    repeat (20) tick();
    check("t1_one_issue", n_issued, 1);
    check("t1_bsy_done",  txbsy,    0);

    // Burst fill while the transmitter is held busy, then overflow
    hold_bsy = 1'b1;
    wr_en    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wr_data = 8'(k);
      tick();
    end
    check("t2_full",     full,  1);
    check("t2_count8",   count, 8);
    check("t2_ovf_pre",  ovf,   0);
    wr_data = 8'h09;
    tick();
    check("t2_ovf_set",  ovf,   1);
    check("t2_count_hold", count, 8);
    clr_flags = 1'b1; wr_data = 8'h0A;
    tick();
    check("t2_ovf_set_wins", ovf, 1);
    wr_en = 1'b0;
    tick();
    clr_flags = 1'b0;
    check("t2_ovf_clr", ovf, 0);
    hold_bsy = 1'b0;
    wait_drain(9, 300);
    for (int i = 1; i <= 8; i++)
      check($sformatf("t2_order_%0d", i), log_b[i], i);
    for (int i = 2; i <= 8; i++)
      check($sformatf("t2_gap_%0d", i), gap_l[i], 2);
    check("t2_empty_end", empty, 1);

    // Move pointers to 4, then push/pop on the same edge across the wrap
    hold_bsy = 1'b1;
    wr_en    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_data = 8'h10 + 8'(k);
      tick();
    end
    wr_en    = 1'b0;
    hold_bsy = 1'b0;
    wait_drain(12, 200);
    hold_bsy = 1'b1;
    wr_en    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_data = 8'h20 + 8'(k);
      tick();
    end
    check("t3_count3", count, 3);
    hold_bsy = 1'b0;
    wr_data  = 8'h23;
    tick();
    check("t3_count_same", count, 3);
    check("t3_txen",       txen,  1);
    check("t3_txreg",      txreg, 8'h20);
    wr_data = 8'h24;
    tick();
    wr_en = 1'b0;
    check("t3_count4", count, 4);
    wait_drain(17, 300);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_order_%0d", i), log_b[12 + i], 8'h20 + i);

    // Handshake timeout
    tx_resp = 1'b0;
    wr_en = 1'b1; wr_data = 8'h30;
    tick();
    wr_data = 8'h31;
    tick();
    wr_en = 1'b0;
    check("t4_txen",  txen,  1);
    check("t4_txreg", txreg, 8'h30);
    check("t4_count", count, 1);
    repeat (3) tick();
    check("t4_err_early", err,  0);
    check("t4_txen_low",  txen, 0);
    tick();
    check("t4_err_set", err, 1);
    tick();
    check("t4_next_txen",  txen,  1);
    check("t4_next_txreg", txreg, 8'h31);
    check("t4_count0",     count, 0);
    tx_resp = 1'b1;
    wait_drain(19, 100);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t4_err_clr", err, 0);

    // Reset while in WAIT_IDLE with four queued bytes and err set
    tx_resp = 1'b0;
    wr_en = 1'b1; wr_data = 8'h40;
    tick();
    wr_en = 1'b0;
    repeat (5) tick();
    check("t5_err_set", err, 1);
    tx_resp = 1'b1;
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    wr_en = 1'b0;
    repeat (2) tick();
    wr_en = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      wr_data = 8'h40 + 8'(k);
      tick();
    end
    wr_en = 1'b0;
    check("t5_count4", count, 4);
    check("t5_busy",   txbsy, 1);
    rst = 1'b1;
    tick();
    check("t5_rst_count", count, 0);
    check("t5_rst_empty", empty, 1);
    check("t5_rst_full",  full,  0);
    check("t5_rst_txen",  txen,  0);
    check("t5_rst_txreg", txreg, 8'h00);
    check("t5_rst_err",   err,   0);
    check("t5_rst_ovf",   ovf,   0);
    rst = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 8'h50;
    tick();
    wr_en = 1'b0;
    check("t5_post_txen_early", txen,  0);
    check("t5_post_count",      count, 1);
    tick();
    check("t5_post_txen",  txen,  1);
    check("t5_post_txreg", txreg, 8'h50);
    wait_drain(22, 100);
    check("handshake_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
